// File: rtl/soml_pkg.sv
// Shared SOML constants, encoder state enum and lane-pack index helper.
// Lane 0 sits in the most significant W bits of a packed 4-lane bus.
package soml_pkg;

  localparam int SOML_W     = 16;
  localparam int SOML_FRAC  = 8;
  localparam int SOML_LANES = 4;

  typedef enum logic [1:0] {
    ENC_FILL  = 2'd0,
    ENC_SEND0 = 2'd1,
    ENC_SEND1 = 2'd2
  } enc_state_t;

  function automatic int lane_lo(input int lane);
    return (SOML_LANES - 1 - lane) * SOML_W;
  endfunction

endpackage

// File: rtl/soml_stbc_enc_if.sv
// Symbol-in / column-out stream bundle for the SOML STBC encoder.
// master = symbol source and column sink; slave = encoder.
interface soml_stbc_enc_if;
  import soml_pkg::*;

  logic                           in_valid;
  logic                           in_ready;
  logic [SOML_W-1:0]              in_r;
  logic [SOML_W-1:0]              in_i;
  logic                           out_valid;
  logic                           out_ready;
  logic                           out_slot;
  logic [SOML_LANES*SOML_W-1:0]   out_r;
  logic [SOML_LANES*SOML_W-1:0]   out_i;

  modport master (
    output in_valid, in_r, in_i, out_ready,
    input  in_ready, out_valid, out_slot, out_r, out_i
  );

  modport slave (
    input  in_valid, in_r, in_i, out_ready,
    output in_ready, out_valid, out_slot, out_r, out_i
  );

endinterface

// File: rtl/soml_neg.sv
// W-bit two's-complement negator. With SOML_ENC_SAT_EN defined the most
// negative value maps to the most positive one instead of wrapping.
module soml_neg
  import soml_pkg::*;
#(
  parameter int W = SOML_W
) (
  input  logic [W-1:0] a,
  output logic [W-1:0] y
);

`ifdef SOML_ENC_SAT_EN
  localparam logic [W-1:0] MIN_VAL = {1'b1, {(W-1){1'b0}}};
  localparam logic [W-1:0] MAX_VAL = {1'b0, {(W-1){1'b1}}};

  assign y = (a == MIN_VAL) ? MAX_VAL : (~a + W'(1));
`else
  assign y = ~a + W'(1);
`endif

endmodule

// File: rtl/soml_stbc_enc.sv
// SOML transmit STBC encoder: buffers 4 Q8.8 symbols, then emits the slot-0
// and slot-1 Alamouti-style columns. Saturating negation: SOML_ENC_SAT_EN.
module soml_stbc_enc
  import soml_pkg::*;
(
  input  logic                  clk,
  input  logic                  rst,
  soml_stbc_enc_if.slave        bus
);

  localparam int BW = SOML_LANES * SOML_W;

  enc_state_t        state, state_nxt;
  logic [1:0]        cnt, cnt_nxt;
  logic [SOML_W-1:0] buf_r     [SOML_LANES];
  logic [SOML_W-1:0] buf_i     [SOML_LANES];
  logic [SOML_W-1:0] buf_r_nxt [SOML_LANES];
  logic [SOML_W-1:0] buf_i_nxt [SOML_LANES];
  logic [BW-1:0]     out_r_nxt, out_i_nxt;
  logic [SOML_W-1:0] neg_s1_r, neg_s0_i, neg_s3_r, neg_s2_i;
  logic              in_fire, out_fire;

  assign in_fire  = bus.in_valid  && bus.in_ready;
  assign out_fire = bus.out_valid && bus.out_ready;

  soml_neg #(.W(SOML_W)) u_neg_s1_r (.a(buf_r[1]), .y(neg_s1_r));
  soml_neg #(.W(SOML_W)) u_neg_s0_i (.a(buf_i[0]), .y(neg_s0_i));
  soml_neg #(.W(SOML_W)) u_neg_s3_r (.a(buf_r[3]), .y(neg_s3_r));
  soml_neg #(.W(SOML_W)) u_neg_s2_i (.a(buf_i[2]), .y(neg_s2_i));

  // Output data is computed one cycle ahead so every port can be a register;
  // the slot-0 column must include the symbol accepted in the same cycle.
  always_comb begin
    state_nxt = state;
    cnt_nxt   = cnt;
    buf_r_nxt = buf_r;
    buf_i_nxt = buf_i;
    out_r_nxt = bus.out_r;
    out_i_nxt = bus.out_i;
    case (state)
      ENC_FILL: begin
        if (in_fire) begin
          buf_r_nxt[cnt] = bus.in_r;
          buf_i_nxt[cnt] = bus.in_i;
          cnt_nxt        = cnt + 2'd1;
          if (cnt == 2'd3) begin
            state_nxt = ENC_SEND0;
            for (int k = 0; k < SOML_LANES; k++) begin
              out_r_nxt[lane_lo(k) +: SOML_W] = buf_r_nxt[k];
              out_i_nxt[lane_lo(k) +: SOML_W] = buf_i_nxt[k];
            end
          end
        end
      end
      ENC_SEND0: begin
        if (out_fire) begin
          state_nxt = ENC_SEND1;
          out_r_nxt = {neg_s1_r, buf_r[0], neg_s3_r, buf_r[2]};
          out_i_nxt = {buf_i[1], neg_s0_i, buf_i[3], neg_s2_i};
        end
      end
      ENC_SEND1: begin
        if (out_fire) begin
          state_nxt = ENC_FILL;
        end
      end
      default: begin
        state_nxt = ENC_FILL;
      end
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state         <= ENC_FILL;
      cnt           <= 2'd0;
      buf_r         <= '{default: '0};
      buf_i         <= '{default: '0};
      bus.in_ready  <= 1'b0;
      bus.out_valid <= 1'b0;
      bus.out_slot  <= 1'b0;
      bus.out_r     <= '0;
      bus.out_i     <= '0;
    end else begin
      state         <= state_nxt;
      cnt           <= cnt_nxt;
      buf_r         <= buf_r_nxt;
      buf_i         <= buf_i_nxt;
      bus.in_ready  <= (state_nxt == ENC_FILL);
      bus.out_valid <= (state_nxt != ENC_FILL);
      bus.out_slot  <= (state_nxt == ENC_SEND1);
      bus.out_r     <= out_r_nxt;
      bus.out_i     <= out_i_nxt;
    end
  end

endmodule

// File: doc/soml_stbc_enc.md
# soml_stbc_enc

Transmit-side space-time block encoder for the SOML link. It accepts a serial stream of complex Q8.8 symbols and buffers four of them. It then emits two packed 64-bit column pairs, one per time slot, in the same 4-lane layout that the SOML decoder consumes on `col0_r/col0_i/col1_r/col1_i`. The block sits between the symbol mapper and the channel/DAC model, and is the encoder counterpart of the decoder's column-product stage.

## Interface
- `W`, 16: symbol component width (signed, two's complement).
- `FRAC`, 8: fractional bits (Q8.8); informational only, no rescaling is performed.
- `LANES`, 4: symbols per block; fixed at 4, other values are unsupported.
- `clk`  in  1  single clock; all logic is on the rising edge.
- `rst`  in  1  asynchronous, active-low reset.
- `in_valid`  in  1  input symbol valid.
- `in_ready`  out  1  encoder can accept a symbol.
- `in_r`  in  W  symbol real part.
- `in_i`  in  W  symbol imaginary part.
- `out_valid`  out  1  output column valid.
- `out_ready`  in  1  downstream accepts the column.
- `out_slot`  out  1  0 = slot-0 column, 1 = slot-1 column.
- `out_r`  out  4*W  packed real lanes; lane 0 in [63:48], lane 3 in [15:0].
- `out_i`  out  4*W  packed imaginary lanes, same lane layout.

## Operation
- FSM states are FILL, SEND0 and SEND1. Reset enters FILL.
- FILL:
  - `in_ready`=1.
  - On `in_valid&&in_ready`, the symbol is stored in buffer slot `cnt` and the 2-bit `cnt` increments.
  - On the 4th accept (`cnt`==3), the block moves to SEND0 and `cnt` wraps to 0.
- SEND0:
  - `out_valid`=1, `out_slot`=0.
  - Lanes carry `[s0, s1, s2, s3]` unmodified.
  - On `out_valid&&out_ready`, the block moves to SEND1.
- SEND1:
  - `out_valid`=1, `out_slot`=1.
  - Lanes carry `[-conj(s1), conj(s0), -conj(s3), conj(s2)]`:
    - `-conj(x)` = (−re, +im).
    - `conj(x)` = (+re, −im).
  - On handshake, the block returns to FILL.
- `in_ready`=0 in SEND0/SEND1. There is no input buffering while sending.
- Negation is W-bit two's complement. Handling of −32768 (0x8000) is set by the configuration macro.
- Output data and `out_slot` are stable while `out_valid`=1 and `out_ready`=0. `out_valid` is never withdrawn without a handshake.

## Timing
- Reset values:
  - `in_ready`=0 while reset is asserted, then 1 from the first cycle after release.
  - `out_valid`=0, `out_slot`=0, `out_r`=0, `out_i`=0.
  - `cnt`=0; buffer contents are cleared to 0.
- All outputs are registered.
- Latency: `out_valid` rises in the cycle after the 4th input handshake.
- SEND1 data is presented in the cycle after the SEND0 handshake.
- `in_ready` rises in the cycle after the SEND1 handshake.
- Peak throughput is 4 symbols per 6 cycles (4 accepts plus 2 sends with `out_ready` held high).
- Backpressure: holding `out_ready`=0 stalls indefinitely with the data held.
- Gaps in `in_valid` during FILL are allowed. A partial block is retained until complete.
- Asserting `rst` mid-FILL or mid-SEND discards the partial or pending block. After release, encoding starts afresh with s0.

## Configuration
- `SOML_ENC_SAT_EN` defined: negating 0x8000 yields 0x7FFF (saturating). All other values negate exactly.
- Undefined: plain wrap-around, so negating 0x8000 yields 0x8000. This is smaller, with no compare logic.

## Structure
- `soml_pkg`: `SOML_W`=16, `SOML_FRAC`=8, `SOML_LANES`=4, the enc state enum (FILL/SEND0/SEND1), and lane-pack index helpers. These are shared with the decoder side.
- One sub-module, `soml_neg`: a W-bit combinational negator with the `SOML_ENC_SAT_EN` saturation option. It is instantiated once per negated component (4 instances for SEND1).

## Test plan
- Basic encode, `out_ready`=1. Input s0=(0100,0080), s1=(FF00,0040), s2=(0080,FF80), s3=(0000,0100).
  - Slot 0: `out_r`=0100FF0000800000, `out_i`=00800040FF800100.
  - Slot 1: `out_r`=0100010000000080, `out_i`=0040FF8001000080.
- Saturation: s1.re=8000, with other fields of the basic test unchanged. Slot-1 lane 0 real is 7FFF with `SOML_ENC_SAT_EN` defined, 8000 without.
- Backpressure: `out_ready`=0 for 5 cycles in SEND0.
  - `out_valid`=1, `out_slot`=0 and the data stay constant.
  - `in_ready`=0 throughout.
  - Slot 1 follows 1 cycle after `out_ready` rises.
- Sparse input: `in_valid` toggles 1,0,0,1,0,1,1. Exactly 4 accepts occur and `out_valid` rises the cycle after the last one.
- Reset mid-operation: pulse `rst` low after 2 accepted symbols, then send 4 new symbols. The output contains only the new symbols, and all outputs were 0 during reset.
- Back-to-back blocks with `out_ready`=1: 8 symbols yield slots 0,1,0,1 in order. `in_ready` rises exactly 1 cycle after each SEND1 handshake.
